// File: rtl/counter_pkg.sv
// Shared mode codes, channel FSM states and wrap-counter width for multi_mode_counter.
// Latency: n/a (definitions only). Backpressure: none.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int WRAPCNT_W = 8;

    // The reserved encoding 2'b11 behaves as WRAP.
    function automatic logic [1:0] decode_mode(input logic [1:0] mode);
        return (mode == 2'b11) ? MODE_WRAP : mode;
    endfunction

endpackage

// File: rtl/multi_mode_counter_if.sv
// Control/status bundle of multi_mode_counter; wrap_cnt exists only with COUNTER_WRAPCNT_EN.
// Latency: n/a (wiring only). Backpressure: none.
interface multi_mode_counter_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       up;
    logic [1:0]              mode;
    logic [WIDTH-1:0]        limit;
    logic                    load;
    logic [CH_W-1:0]         load_ch;
    logic [WIDTH-1:0]        load_value;
    logic [NUM_CH*WIDTH-1:0] contador;
    logic [NUM_CH-1:0]       valid;
    logic [NUM_CH-1:0]       tc;
`ifdef COUNTER_WRAPCNT_EN
    logic [NUM_CH*counter_pkg::WRAPCNT_W-1:0] wrap_cnt;
`endif

    modport master (
        output enable, up, mode, limit, load, load_ch, load_value,
`ifdef COUNTER_WRAPCNT_EN
        input  wrap_cnt,
`endif
        input  contador, valid, tc
    );

    modport slave (
        input  enable, up, mode, limit, load, load_ch, load_value,
`ifdef COUNTER_WRAPCNT_EN
        output wrap_cnt,
`endif
        output contador, valid, tc
    );

endinterface

// File: rtl/counter_channel.sv
// One counter channel: IDLE/RUN/DONE FSM, boundary handling, tc pulse, optional wrap count (COUNTER_WRAPCNT_EN).
// Latency: 1 clk from sampled enable/load to count and tc. Backpressure: none.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_up,
    input  logic [1:0]           i_mode,
    input  logic [WIDTH-1:0]     i_limit,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_load_value,
`ifdef COUNTER_WRAPCNT_EN
    output logic [WRAPCNT_W-1:0] o_wrap_cnt,
`endif
    output logic [WIDTH-1:0]     o_cnt,
    output logic                 o_valid,
    output logic                 o_tc
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic [1:0]       w_mode;
    logic             w_at_bnd;
    logic             w_run_like;
    logic [WIDTH-1:0] w_step;

    assign w_mode   = decode_mode(i_mode);
    // >= rather than == so a limit lowered below the count still terminates.
    assign w_at_bnd = i_up ? (r_cnt >= i_limit) : (r_cnt == '0);
    assign w_step   = i_up ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
    // IDLE steps exactly like RUN; DONE only does so once the mode is WRAP.
    assign w_run_like = (r_state != ST_DONE) || (w_mode == MODE_WRAP);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_tc_nxt    = 1'b0;
        if (i_load) begin
            w_cnt_nxt   = (i_load_value > i_limit) ? i_limit : i_load_value;
            w_state_nxt = ST_RUN;
            w_valid_nxt = 1'b1;
        end else if (i_enable) begin
            w_valid_nxt = 1'b1;
            if (w_run_like) begin
                w_state_nxt = ST_RUN;
                if (!w_at_bnd) begin
                    w_cnt_nxt = w_step;
                end else begin
                    w_tc_nxt = 1'b1;
                    case (w_mode)
                        MODE_SAT: begin
                            if (i_up) begin
                                w_cnt_nxt = i_limit;
                            end
                            w_state_nxt = ST_DONE;
                        end
                        MODE_ONESHOT: w_state_nxt = ST_DONE;
                        default:      w_cnt_nxt = i_up ? '0 : i_limit;
                    endcase
                end
            end else if ((w_mode == MODE_SAT) && !w_at_bnd) begin
                w_cnt_nxt   = w_step;
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_valid = r_valid;
    assign o_tc    = r_tc;

`ifdef COUNTER_WRAPCNT_EN
    logic [WRAPCNT_W-1:0] r_wrap_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap_cnt <= '0;
        end else if (i_load) begin
            r_wrap_cnt <= '0;
        end else if (w_tc_nxt && (r_wrap_cnt != '1)) begin
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end

    assign o_wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: rtl/multi_mode_counter.sv
// NUM_CH independent WRAP/SAT/ONESHOT counters with shared limit and per-channel load; COUNTER_WRAPCNT_EN adds wrap_cnt.
// Latency: 1 clk, all outputs registered. Backpressure: none.
module multi_mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_mode_counter_if.slave  bus
);

    logic [WIDTH-1:0] w_cnt   [NUM_CH];
    logic             w_valid [NUM_CH];
    logic             w_tc    [NUM_CH];
`ifdef COUNTER_WRAPCNT_EN
    logic [WRAPCNT_W-1:0] w_wrap [NUM_CH];
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_load_hit;

        // Exact-match decode: load_ch values >= NUM_CH select no channel.
        assign w_load_hit = bus.load && (bus.load_ch == CH_W'(i));

        counter_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_enable     (bus.enable[i]),
            .i_up         (bus.up[i]),
            .i_mode       (bus.mode),
            .i_limit      (bus.limit),
            .i_load       (w_load_hit),
            .i_load_value (bus.load_value),
`ifdef COUNTER_WRAPCNT_EN
            .o_wrap_cnt   (w_wrap[i]),
`endif
            .o_cnt        (w_cnt[i]),
            .o_valid      (w_valid[i]),
            .o_tc         (w_tc[i])
        );
    end

    always_comb begin
        bus.contador = '0;
        bus.valid    = '0;
        bus.tc       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.contador[i*WIDTH +: WIDTH] = w_cnt[i];
            bus.valid[i]                   = w_valid[i];
            bus.tc[i]                      = w_tc[i];
        end
    end

`ifdef COUNTER_WRAPCNT_EN
    always_comb begin
        bus.wrap_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.wrap_cnt[i*WRAPCNT_W +: WRAPCNT_W] = w_wrap[i];
        end
    end
`endif

endmodule
